mem_bus_arbiter: RTL and testbench

- Shares the single memory-controller port between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Serialises accesses, one transaction in flight at a time.
- Holds the bus stable while the flash reports busy.
- Returns read data and the error flag to the winning requester with a one-cycle ack.
- Sits between the CPU pipeline and the memory controller.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-requester memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  typedef enum logic {
    OwnData  = 1'b0,
    OwnFetch = 1'b1
  } owner_e;

  localparam int unsigned DefMaxDataStreak = 4;
  localparam int unsigned DefTimeout       = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select with anti-starvation streak update for fetch vs data.
module mem_arb_pick
  import mem_bus_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DefMaxDataStreak,
  parameter int unsigned StreakW         = $clog2(MAX_DATA_STREAK + 1)
) (
  input  logic               if_req_i,
  input  logic               d_req_i,
  input  logic [StreakW-1:0] streak_q_i,
  output logic               grant_o,
  output owner_e             owner_o,
  output logic [StreakW-1:0] streak_d_o
);

  logic streak_full;
  assign streak_full = (streak_q_i == StreakW'(MAX_DATA_STREAK));

  always_comb begin
    grant_o    = if_req_i | d_req_i;
    owner_o    = OwnData;
    streak_d_o = streak_q_i;
    if (if_req_i && (!d_req_i || streak_full)) begin
      owner_o    = OwnFetch;
      streak_d_o = '0;
    end else if (d_req_i) begin
      owner_o = OwnData;
      // Only data wins that starve a waiting fetch count towards the streak.
      if (if_req_i) begin
        streak_d_o = streak_full ? streak_q_i : streak_q_i + StreakW'(1);
      end else begin
        streak_d_o = '0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises fetch and load/store accesses onto one memory-controller port.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DefMaxDataStreak,
  parameter int unsigned TIMEOUT         = DefTimeout
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  input  logic        mem_busy
);

  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

  state_e             state_q;
  owner_e             owner_q, pick_owner;
  logic               pick_grant;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [TmoW-1:0]    tmo_q;
  logic               mem_valid_q, mem_write_q, ack_q, rsp_err_q;
  logic [31:0]        mem_addr_q, mem_wdata_q, rsp_rdata_q;

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK),
    .StreakW        (StreakW)
  ) u_pick (
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .streak_q_i(streak_q),
    .grant_o   (pick_grant),
    .owner_o   (pick_owner),
    .streak_d_o(streak_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnData;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_grant) begin
            state_q     <= StIssue;
            owner_q     <= pick_owner;
            streak_q    <= streak_d;
            mem_valid_q <= 1'b1;
            if (pick_owner == OwnFetch) begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end else begin
              mem_write_q <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (!mem_busy || (tmo_q == TmoW'(TIMEOUT - 1))) begin
            state_q     <= StResp;
            ack_q       <= 1'b1;
            // A timed-out access reports an error with no data.
            rsp_err_q   <= mem_busy ? 1'b1 : mem_error;
            rsp_rdata_q <= (mem_busy || mem_write_q) ? '0 : mem_rdata;
            mem_valid_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StResp: begin
          state_q     <= StIdle;
          ack_q       <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          tmo_q       <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign if_ack   = ack_q && (owner_q == OwnFetch);
  assign d_ack    = ack_q && (owner_q == OwnData);
  assign if_rdata = if_ack ? rsp_rdata_q : '0;
  assign d_rdata  = d_ack ? rsp_rdata_q : '0;
  assign if_err   = if_ack & rsp_err_q;
  assign d_err    = d_ack & rsp_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed vectors, corner sequences and a timestamp-based reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam int unsigned Tmo       = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        mem_error = 1'b0, mem_busy = 1'b0;
  logic        if_ack, if_err, d_ack, d_err, mem_valid, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(
    .MAX_DATA_STREAK(MaxStreak),
    .TIMEOUT        (Tmo)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_error(mem_error),
    .mem_busy (mem_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the edge a transaction was granted (g) and the
  // edge its response was decided (a); everything else follows from those.
  int          ecnt = 0;
  int          g = -1, a = -1;
  int          streak = 0;
  bit          m_fetch, m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_rd;

  task automatic model_edge();
    bit fetch_wins;
    int k;
    ecnt++;
    if (rst) begin
      g = -1; a = -1; streak = 0;
    end else if (g < 0) begin
      if (if_req || d_req) begin
        fetch_wins = if_req && (!d_req || streak == int'(MaxStreak));
        if (fetch_wins) streak = 0;
        else if (if_req) streak = (streak + 1 > int'(MaxStreak)) ? int'(MaxStreak) : streak + 1;
        else streak = 0;
        m_fetch = fetch_wins;
        m_we    = fetch_wins ? 1'b0 : d_we;
        m_addr  = fetch_wins ? if_addr : d_addr;
        m_wdata = fetch_wins ? 32'h0 : d_wdata;
        g = ecnt;
      end
    end else if (a < 0) begin
      if (ecnt >= g + 2) begin
        k = ecnt - g - 1;  // 1-based index of the wait cycle just ending
        if (!mem_busy) begin
          a = ecnt; m_err = mem_error; m_rd = m_we ? 32'h0 : mem_rdata;
        end else if (k == int'(Tmo)) begin
          a = ecnt; m_err = 1'b1; m_rd = 32'h0;
        end
      end
    end else begin
      g = -1; a = -1;
    end
  endtask

  task automatic check_outputs();
    bit v, ack, ia, da;
    v   = (g >= 0) && (a < 0);
    ack = (g >= 0) && (a == ecnt);
    ia  = ack && m_fetch;
    da  = ack && !m_fetch;
    chk("ctl{valid,write,if_ack,d_ack,if_err,d_err}",
        {26'h0, mem_valid, mem_write, if_ack, d_ack, if_err, d_err},
        {26'h0, v, v & m_we, ia, da, ia & m_err, da & m_err});
    chk("mem_addr", mem_addr, v ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata, v ? m_wdata : 32'h0);
    chk("if_rdata", if_rdata, ia ? m_rd : 32'h0);
    chk("d_rdata", d_rdata, da ? m_rd : 32'h0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  end

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err_in;
    int          busy_n;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    mem_rdata = v.rdata; mem_error = v.err_in;
    while (!got && lat < 40) begin
      mem_busy = (lat < v.busy_n + 2);
      @(posedge clk); #2;
      lat++;
      got = v.fetch ? if_ack : d_ack;
      if (got) begin
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " rdata"}, v.fetch ? if_rdata : d_rdata, v.exp_rdata);
        chk({tag, " err"}, {31'h0, v.fetch ? if_err : d_err}, {31'h0, v.exp_err});
      end
      @(negedge clk);
    end
    if (!got) chk({tag, " ack seen"}, 32'h0, 32'h1);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    mem_busy = 1'b0; mem_error = 1'b0;
  endtask

  vec_t vecs[7];
  string seq_got;
  int burst;

  initial begin
    vecs[0] = '{1, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 3, 32'hDEAD_BEEF, 0};
    vecs[1] = '{0, 1, 32'h0001_0004, 32'h1234_5678, 32'hAAAA_5555, 0, 0, 3, 32'h0, 0};
    vecs[2] = '{0, 0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1, 0, 3, 32'hCAFE_F00D, 1};
    vecs[3] = '{1, 0, 32'h0000_0104, 32'h0, 32'h1122_3344, 0, 5, 8, 32'h1122_3344, 0};
    vecs[4] = '{0, 0, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF, 0, 100, 10, 32'h0, 1};
    vecs[5] = '{0, 1, 32'h0000_3004, 32'h5A5A_0001, 32'h7777_7777, 1, 7, 10, 32'h0, 1};
    vecs[6] = '{1, 0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0, 100, 10, 32'h0, 1};

    repeat (2) @(posedge clk);
    #2;
    chk("reset if_ack/d_ack/mem_valid", {29'h0, if_ack, d_ack, mem_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held high: four data grants, then fetch is forced in.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_8000;
    seq_got = "";
    for (int c = 0; c < 100 && seq_got.len() < 10; c++) begin
      @(posedge clk); #2;
      if (if_ack) seq_got = {seq_got, "F"};
      if (d_ack) seq_got = {seq_got, "D"};
    end
    n_cmp++;
    if (seq_got != "DDDDFDDDDF") begin
      n_bad++;
      $display("FAIL grant order: got %s, expected DDDDFDDDDF", seq_got);
    end
    @(negedge clk); if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Request dropped right after being granted must still complete.
    if_req = 1'b1; if_addr = 32'h0000_0500; mem_rdata = 32'h0F0F_0F0F;
    @(negedge clk); if_req = 1'b0;
    burst = 0;
    for (int c = 0; c < 10 && burst == 0; c++) begin
      @(posedge clk); #2;
      if (if_ack) burst = c + 2;
    end
    chk("dropped req latency", 32'(burst), 32'd3);
    repeat (2) @(negedge clk);

    // Reset while waiting on a busy flash: no ack, bus released, then a clean access.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000; mem_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre-reset mem_valid", {31'h0, mem_valid}, 32'h1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #2;
    chk("post-reset {valid,if_ack,d_ack}", {29'h0, mem_valid, if_ack, d_ack}, 32'h0);
    @(negedge clk); rst = 1'b0; mem_busy = 1'b0;
    run_vec(vecs[2], "after-reset");

    // Randomised traffic checked cycle by cycle against the model.
    burst = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (if_req && if_ack) if_req = 1'b0;
      else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (d_req && d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end
      if (burst > 0) burst--;
      else if ($urandom_range(9) == 0) burst = $urandom_range(12);
      mem_busy  = (burst > 0);
      mem_rdata = $urandom;
      mem_error = ($urandom_range(7) == 0);
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
